// File: rtl/data_mem_requester_if.sv
// Pipeline-to-memory bundle for data_mem_requester: request/response handshake plus the
// DataMemory port. The requester sits on the slave modport; pipeline and memory drive master.
interface data_mem_requester_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          busy;
    logic          WE;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    logic [DW-1:0] RD;
    logic          MemReady;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, RD, MemReady,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy, WE, A, WD
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, RD, MemReady,
        output req_ready, resp_valid, resp_rdata, resp_err, busy, WE, A, WD
    );
endinterface

// File: rtl/data_mem_requester.sv
// MEM-stage initiator for the DataMemory port: one load/store at a time, registered WE/A/WD.
// Define MEM_TIMEOUT_EN to give up on MemReady after TIMEOUT read cycles.
module data_mem_requester #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_requester_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("data_mem_requester: TIMEOUT must be at least 1");
    end

    state_t        state;
    logic          req_ready_q;
    logic          settle_q;
    logic          we_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] wd_q;
    logic          resp_valid_q;
    logic [DW-1:0] resp_rdata_q;
    logic          resp_err_q;
    logic          accept;
    logic          misaligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);
    logic [CW-1:0] rd_cnt;
`endif

    assign accept     = bus.req_valid & req_ready_q;
    assign misaligned = (bus.req_addr[1:0] != 2'b00);

    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = ~req_ready_q;
    assign bus.WE         = we_q;
    assign bus.A          = a_q;
    assign bus.WD         = wd_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            settle_q     <= 1'b0;
            we_q         <= 1'b0;
            a_q          <= '0;
            wd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            rd_cnt       <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (misaligned) begin
                            // Rejected without touching the memory port.
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write) begin
                            state <= WRITE;
                            a_q   <= bus.req_addr;
                            wd_q  <= bus.req_wdata;
                            we_q  <= 1'b1;
                        end else begin
                            state    <= READ;
                            a_q      <= bus.req_addr;
                            we_q     <= 1'b0;
                            settle_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            rd_cnt   <= '0;
`endif
                        end
                    end
                end
                WRITE: begin
                    we_q         <= 1'b0;
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                end
                READ: begin
                    // First READ cycle ignores MemReady: it may still refer to the previous address.
                    settle_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    rd_cnt   <= rd_cnt + 1'b1;
`endif
                    if (!settle_q && bus.MemReady) begin
                        resp_rdata_q <= bus.RD;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (rd_cnt == CW'(TIMEOUT - 1)) begin
                        resp_rdata_q <= TIMEOUT_DATA;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
`endif
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    we_q        <= 1'b0;
                end
            endcase
        end
    end
endmodule
